// File: rtl/bcd_decimal_scanner.sv
// Multi-digit BCD scanner: accepts a packed word of BCD digits and emits one
// one-hot decimal code per digit, most-significant first, under valid/ready flow control.
module bcd_decimal_scanner #(
  parameter int NDIGITS   = 4,
  parameter int ERR_CNT_W = 8,
  parameter int IDX_W     = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [4*NDIGITS-1:0]   BCDIn,
  input  logic                   InValid,
  output logic                   InReady,
  input  logic                   BlankEn,
  output logic [9:0]             DECOut,
  output logic [IDX_W-1:0]       DigitIdx,
  output logic                   OutValid,
  input  logic                   OutReady,
  output logic                   OutLast,
  output logic                   DigErr,
  output logic                   Blanked,
  output logic                   WordErr,
  output logic [ERR_CNT_W-1:0]   ErrCnt
);

  typedef enum logic [0:0] {IDLE = 1'b0, SCAN = 1'b1} state_t;

  localparam logic [IDX_W-1:0]     IDX_TOP = IDX_W'(NDIGITS - 1);
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};

  function automatic logic [9:0] onehot10(input logic [3:0] d);
    logic [9:0] r;
    if (d > 4'd9) r = 10'b00_0000_0000;
    else          r = 10'b00_0000_0001 << d;
    return r;
  endfunction

  function automatic logic any_invalid(input logic [4*NDIGITS-1:0] w);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (w[4*i +: 4] > 4'd9) r = 1'b1;
      else                    r = r;
    end
    return r;
  endfunction

  state_t                 state_r, state_n;
  logic [4*NDIGITS-1:0]   word_r, word_n;
  logic                   blank_r, blank_n;
  logic                   lz_r, lz_n;          // all digits emitted so far are zero
  logic                   werr_cap_r, werr_cap_n;
  logic [IDX_W-1:0]       idx_r, idx_n;
  logic [9:0]             dec_r, dec_n;
  logic                   dig_err_r, dig_err_n;
  logic                   blanked_r, blanked_n;
  logic                   last_r, last_n;
  logic                   word_err_r, word_err_n;
  logic [ERR_CNT_W-1:0]   err_cnt_r, err_cnt_n;

  logic                   in_ready_s, accept_s, xfer_s, load_s;
  logic [3:0]             digit_s;
  logic                   lz_prev_s, blank_s, werr_s, zero_s, is_last_s;
  logic [IDX_W-1:0]       idx_dec_s;

  assign in_ready_s = (state_r == IDLE) || (last_r && OutReady);
  assign accept_s   = InValid && in_ready_s;
  assign xfer_s     = (state_r == SCAN) && OutReady;
  assign idx_dec_s  = idx_r - IDX_W'(1);

  // Next-state, digit selection, decode and error counter.
  always_comb begin
    state_n    = state_r;
    word_n     = word_r;
    blank_n    = blank_r;
    lz_n       = lz_r;
    werr_cap_n = werr_cap_r;
    idx_n      = idx_r;
    dec_n      = dec_r;
    dig_err_n  = dig_err_r;
    blanked_n  = blanked_r;
    last_n     = last_r;
    word_err_n = word_err_r;
    load_s     = 1'b0;
    digit_s    = 4'd0;
    lz_prev_s  = 1'b0;
    blank_s    = 1'b0;
    werr_s     = 1'b0;

    if (xfer_s && dig_err_r && (err_cnt_r != CNT_MAX)) err_cnt_n = err_cnt_r + ERR_CNT_W'(1);
    else                                               err_cnt_n = err_cnt_r;

    if (accept_s) begin
      state_n    = SCAN;
      word_n     = BCDIn;
      blank_n    = BlankEn;
      werr_cap_n = any_invalid(BCDIn);
      idx_n      = IDX_TOP;
      digit_s    = BCDIn[4*(NDIGITS-1) +: 4];
      lz_prev_s  = 1'b1;
      blank_s    = BlankEn;
      werr_s     = werr_cap_n;
      load_s     = 1'b1;
    end else if (xfer_s && last_r) begin
      state_n    = IDLE;
      dec_n      = 10'b00_0000_0000;
      dig_err_n  = 1'b0;
      blanked_n  = 1'b0;
      last_n     = 1'b0;
      word_err_n = 1'b0;
    end else if (xfer_s) begin
      idx_n      = idx_dec_s;
      digit_s    = word_r[4*int'(idx_dec_s) +: 4];
      lz_prev_s  = lz_r;
      blank_s    = blank_r;
      werr_s     = werr_cap_r;
      load_s     = 1'b1;
    end else begin
      state_n    = state_r;
    end

    zero_s    = (digit_s == 4'd0);
    is_last_s = (idx_n == IDX_W'(0));
    if (load_s) begin
      lz_n       = lz_prev_s && zero_s;
      blanked_n  = blank_s && lz_prev_s && zero_s && !is_last_s;
      dec_n      = blanked_n ? 10'b00_0000_0000 : onehot10(digit_s);
      dig_err_n  = (digit_s > 4'd9);
      last_n     = is_last_s;
      word_err_n = is_last_s && werr_s;
    end else begin
      lz_n       = lz_n;
    end
  end

  // State and registered outputs; synchronous reset discards any word in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r    <= IDLE;
      word_r     <= '0;
      blank_r    <= 1'b0;
      lz_r       <= 1'b0;
      werr_cap_r <= 1'b0;
      idx_r      <= '0;
      dec_r      <= 10'b00_0000_0000;
      dig_err_r  <= 1'b0;
      blanked_r  <= 1'b0;
      last_r     <= 1'b0;
      word_err_r <= 1'b0;
      err_cnt_r  <= '0;
    end else begin
      state_r    <= state_n;
      word_r     <= word_n;
      blank_r    <= blank_n;
      lz_r       <= lz_n;
      werr_cap_r <= werr_cap_n;
      idx_r      <= idx_n;
      dec_r      <= dec_n;
      dig_err_r  <= dig_err_n;
      blanked_r  <= blanked_n;
      last_r     <= last_n;
      word_err_r <= word_err_n;
      err_cnt_r  <= err_cnt_n;
    end
  end

  assign InReady  = in_ready_s;
  assign OutValid = (state_r == SCAN);
  assign DECOut   = dec_r;
  assign DigitIdx = idx_r;
  assign OutLast  = last_r;
  assign DigErr   = dig_err_r;
  assign Blanked  = blanked_r;
  assign WordErr  = word_err_r;
  assign ErrCnt   = err_cnt_r;

endmodule

// File: tb/tb_bcd_decimal_scanner.sv
// Scoreboard bench for bcd_decimal_scanner: a driver pushes per-digit expectations
// computed from the word value, a negedge monitor pops and compares them.
module tb_bcd_decimal_scanner;

  localparam int N  = 4;
  localparam int EW = 3;
  localparam int IW = 2;
  localparam int XW = 10 + IW + 4 + EW;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [4*N-1:0] BCDIn = '0;
  logic          InValid = 1'b0;
  logic          InReady;
  logic          BlankEn = 1'b0;
  logic [9:0]    DECOut;
  logic [IW-1:0] DigitIdx;
  logic          OutValid;
  logic          OutReady = 1'b1;
  logic          OutLast;
  logic          DigErr;
  logic          Blanked;
  logic          WordErr;
  logic [EW-1:0] ErrCnt;

  always #5 CLK = ~CLK;

  bcd_decimal_scanner #(.NDIGITS(N), .ERR_CNT_W(EW), .IDX_W(IW)) dut (
    .CLK(CLK), .RST(RST), .BCDIn(BCDIn), .InValid(InValid), .InReady(InReady),
    .BlankEn(BlankEn), .DECOut(DECOut), .DigitIdx(DigitIdx), .OutValid(OutValid),
    .OutReady(OutReady), .OutLast(OutLast), .DigErr(DigErr), .Blanked(Blanked),
    .WordErr(WordErr), .ErrCnt(ErrCnt)
  );

  logic [XW-1:0] exp_q[$];
  int checks = 0;
  int passes = 0;
  int err_model = 0;
  int rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Expected digit stream from the word value: blanked when every digit from i upward is zero.
  task automatic push_word(input logic [4*N-1:0] w, input logic blank);
    logic [3:0] d;
    logic       bl, bad, werr;
    logic [9:0] dec;
    werr = 1'b0;
    for (int i = 0; i < N; i++) if (w[4*i +: 4] > 4'd9) werr = 1'b1;
    for (int i = N - 1; i >= 0; i--) begin
      d   = w[4*i +: 4];
      bad = (d > 4'd9);
      bl  = blank && (i != 0) && ((w >> (4*i)) == 0);
      dec = (bad || bl) ? 10'd0 : (10'd1 << d);
      exp_q.push_back({dec, IW'(i), (i == 0), bad, bl, (i == 0) && werr, EW'(err_model)});
      if (bad && err_model < (1 << EW) - 1) err_model++;
    end
  endtask

  task automatic send_word(input logic [4*N-1:0] w, input logic blank);
    int waited;
    bit ok;
    BCDIn = w; BlankEn = blank; InValid = 1'b1;
    ok = 1'b0;
    waited = 0;
    while (!ok && waited < 100) begin
      @(negedge CLK);
      if (InReady) ok = 1'b1;
      waited++;
    end
    if (!ok) begin
      check("accept_timeout", 32'd0, 32'd1);
      @(posedge CLK); #1;
      InValid = 1'b0;
    end else begin
      @(posedge CLK); #1;
      push_word(w, blank);
      InValid = 1'b0;
      BCDIn = 16'($urandom);
      BlankEn = 1'($urandom);
    end
  endtask

  task automatic reset_mid_scan(input logic [4*N-1:0] w);
    send_word(w, 1'b0);
    @(posedge CLK); #1;
    RST = 1'b1;
    err_model = 0;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check("rst_mid_scan", {OutValid, DECOut, ErrCnt, InReady}, 32'd1);
    @(posedge CLK); #1;
  endtask

  // OutReady generator, updated just after each rising edge.
  always @(posedge CLK) begin
    #2;
    case (rdy_mode)
      0:       OutReady = 1'b1;
      1:       OutReady = 1'($urandom_range(0, 1));
      default: OutReady = 1'b0;
    endcase
  end

  // Monitor: compares the presented digit with the scoreboard head, pops on transfer.
  always @(negedge CLK) begin
    if (RST) begin
      exp_q.delete();
    end else begin
      check("in_ready", 32'(InReady), 32'((exp_q.size() == 0) || (exp_q.size() == 1 && OutReady)));
      check("out_valid", 32'(OutValid), 32'(exp_q.size() > 0));
      if (exp_q.size() == 0) check("err_cnt_idle", 32'(ErrCnt), 32'(err_model));
      if (OutValid && exp_q.size() > 0) begin
        check("digit", 32'({DECOut, DigitIdx, OutLast, DigErr, Blanked, WordErr, ErrCnt}), 32'(exp_q[0]));
        if (OutReady) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    int waited;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("reset_state", 32'({OutValid, DECOut, DigitIdx, OutLast, DigErr, Blanked, WordErr, ErrCnt, InReady}), 32'd1);
    @(posedge CLK); #1;

    send_word(16'h0907, 1'b0);
    send_word(16'h0907, 1'b1);
    send_word(16'h0000, 1'b1);
    send_word(16'h1A3F, 1'b0);
    for (int k = 0; k < 3; k++) send_word(16'hAA9A, 1'b1);
    send_word(16'h1234, 1'b0);
    send_word(16'h5678, 1'b0);

    send_word(16'h4567, 1'b0);
    @(posedge CLK); #1;
    rdy_mode = 2;
    repeat (3) @(posedge CLK);
    #1 rdy_mode = 0;

    reset_mid_scan(16'h4567);

    rdy_mode = 1;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 39) == 0) reset_mid_scan(16'($urandom));
      send_word(16'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 4)) @(posedge CLK);
        #1;
      end
    end

    rdy_mode = 0;
    waited = 0;
    while (exp_q.size() != 0 && waited < 50) begin
      @(posedge CLK);
      waited++;
    end
    @(negedge CLK);
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
